// File: rtl/neopixel_pkg.sv
// neopixel_pkg
// Shared definitions for the WS2812 ("NeoPixel") receiver and transmitter:
//   - cycle constants referenced to a 125 MHz clock (receiver thresholds and
//     transmitter pulse widths),
//   - receiver state encoding,
//   - scale_cycles(): rescales a 125 MHz cycle count to another clock rate.
package neopixel_pkg;

    localparam int C_BASE_FREQ_HZ    = 125000000;

    // Receiver thresholds (cycles at 125 MHz)
    localparam int C_GLITCH_CYCLES   = 19;    // shorter high pulse is a glitch
    localparam int C_T1_MIN_CYCLES   = 75;    // high pulse >= this decodes as '1'
    localparam int C_MAX_HIGH_CYCLES = 188;   // longer high pulse is a violation
    localparam int C_RESET_CYCLES    = 6250;  // low gap that latches a frame

    // Transmitter pulse widths (cycles at 125 MHz)
    localparam int C_T0H_CYCLES      = 50;
    localparam int C_T0L_CYCLES      = 108;
    localparam int C_T1H_CYCLES      = 100;
    localparam int C_T1L_CYCLES      = 55;
    localparam int C_START_CYCLES    = 7000;  // idle low before the first frame

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Rescale a 125 MHz cycle count to freq_hz (truncating).
    function automatic int scale_cycles(input int cycles, input int freq_hz);
        longint l_prod;
        l_prod = longint'(cycles) * longint'(freq_hz);
        return int'(l_prod / longint'(C_BASE_FREQ_HZ));
    endfunction

endpackage

// File: rtl/neopixel_sync.sv
// neopixel_sync
// Two-flop synchronizer for the asynchronous serial line plus edge detect.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_din          : raw asynchronous serial input
//   o_s            : synchronized sample
//   o_rise, o_fall : single-cycle edge flags of o_s (combinational)
module neopixel_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_s    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/neopixel_rx.sv
// neopixel_rx
// WS2812 serial receiver. Measures each high pulse on the synchronized line,
// decodes 0/1 bits (GRB order, MSB first), assembles 24-bit pixels and
// detects the frame latch gap.
// Ports:
//   neopixel_clock / neopixel_reset_n : clock, asynchronous active-low reset
//   neopixel_din   : asynchronous serial line
//   pixel_valid    : 1-cycle strobe, pixel_data {R,G,B} and pixel_index valid
//   frame_done     : 1-cycle strobe on latch gap, with frame_pixels,
//                    frame_partial (stray bits dropped), frame_overflow
//   bit_error      : 1-cycle strobe on a high-pulse timing violation
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int C_FREQ_HZ    = 125000000,
    parameter int C_MAX_PIXELS = 12
) (
    input  logic        neopixel_clock,
    input  logic        neopixel_reset_n,
    input  logic        neopixel_din,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic [7:0]  frame_pixels,
    output logic        frame_partial,
    output logic        frame_overflow,
    output logic        bit_error
);

    localparam int L_GLITCH   = scale_cycles(C_GLITCH_CYCLES, C_FREQ_HZ);
    localparam int L_T1_MIN   = scale_cycles(C_T1_MIN_CYCLES, C_FREQ_HZ);
    localparam int L_MAX_HIGH = scale_cycles(C_MAX_HIGH_CYCLES, C_FREQ_HZ);
    localparam int L_RESET    = scale_cycles(C_RESET_CYCLES, C_FREQ_HZ);
    localparam int L_HCNT_W   = $clog2(L_MAX_HIGH + 2);
    localparam int L_LCNT_W   = $clog2(L_RESET + 1);

    localparam logic [L_HCNT_W-1:0] L_GLITCH_H = L_HCNT_W'(L_GLITCH);
    localparam logic [L_HCNT_W-1:0] L_T1_MIN_H = L_HCNT_W'(L_T1_MIN);
    localparam logic [L_HCNT_W-1:0] L_HIGH_SAT = L_HCNT_W'(L_MAX_HIGH + 1);
    localparam logic [L_LCNT_W-1:0] L_LOW_LAST = L_LCNT_W'(L_RESET - 1);
    localparam logic [7:0]          L_MAX_PIX  = 8'(C_MAX_PIXELS);

    logic                w_s;
    logic                w_rise;
    logic                w_fall;
    state_t              r_state;
    state_t              w_state_next;
    logic [L_HCNT_W-1:0] r_high_cnt;
    logic [L_LCNT_W-1:0] r_low_cnt;
    logic [4:0]          r_bit_cnt;
    logic [23:0]         r_shift;
    logic [7:0]          r_next_index;
    logic [7:0]          r_pix_cnt;

    logic                w_low_full;
    logic                w_high_over;
    logic                w_bit_val;
    logic                w_frame_open;
    logic [23:0]         w_shift_next;
    logic                w_bit_done;
    logic                w_bit_err;
    logic                w_frame_end;
    logic                w_sync_exit;

    neopixel_sync u_sync (
        .i_clk   (neopixel_clock),
        .i_rst_n (neopixel_reset_n),
        .i_din   (neopixel_din),
        .o_s     (w_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // The current s==0 cycle is the last one needed to complete a latch gap.
    assign w_low_full   = (r_low_cnt == L_LOW_LAST);
    assign w_high_over  = (r_high_cnt == L_HIGH_SAT);
    assign w_bit_val    = (r_high_cnt >= L_T1_MIN_H);
    assign w_frame_open = (r_pix_cnt != 8'd0) || (r_bit_cnt != 5'd0);
    assign w_shift_next = {r_shift[22:0], w_bit_val};

    // State register.
    always_ff @(posedge neopixel_clock or negedge neopixel_reset_n) begin
        if (!neopixel_reset_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SYNC, ST_ERROR: begin
                if (w_sync_exit) w_state_next = ST_IDLE;
                else             w_state_next = r_state;
            end
            ST_IDLE, ST_LOW: begin
                if (w_rise)           w_state_next = ST_HIGH;
                else if (w_frame_end) w_state_next = ST_IDLE;
                else                  w_state_next = r_state;
            end
            ST_HIGH: begin
                if (w_bit_err)       w_state_next = ST_ERROR;
                else if (w_bit_done) w_state_next = ST_LOW;
                else                 w_state_next = ST_HIGH;
            end
            default: w_state_next = ST_SYNC;
        endcase
    end

    // Per-state decisions consumed by the datapath.
    // A falling edge can only see a count above the maximum when it equals the
    // saturation value, so w_high_over covers both the "too long at fall" and
    // the "stuck high" cases.
    always_comb begin
        w_bit_done  = 1'b0;
        w_bit_err   = 1'b0;
        w_frame_end = 1'b0;
        w_sync_exit = 1'b0;
        case (r_state)
            ST_SYNC, ST_ERROR: begin
                if (!w_s && w_low_full) w_sync_exit = 1'b1;
                else                    w_sync_exit = 1'b0;
            end
            ST_HIGH: begin
                if (w_high_over) begin
                    w_bit_err = 1'b1;
                end else if (w_fall) begin
                    if (r_high_cnt < L_GLITCH_H) w_bit_err  = 1'b1;
                    else                         w_bit_done = 1'b1;
                end else begin
                    w_bit_done = 1'b0;
                end
            end
            ST_IDLE: begin
                if (!w_s && w_low_full && w_frame_open) w_frame_end = 1'b1;
                else                                    w_frame_end = 1'b0;
            end
            ST_LOW: begin
                if (!w_s && w_low_full) w_frame_end = 1'b1;
                else                    w_frame_end = 1'b0;
            end
            default: w_frame_end = 1'b0;
        endcase
    end

    // Pulse/gap counters, bit and pixel assembly, registered outputs.
    always_ff @(posedge neopixel_clock or negedge neopixel_reset_n) begin
        if (!neopixel_reset_n) begin
            r_high_cnt     <= '0;
            r_low_cnt      <= '0;
            r_bit_cnt      <= 5'd0;
            r_shift        <= 24'h0;
            r_next_index   <= 8'd0;
            r_pix_cnt      <= 8'd0;
            pixel_valid    <= 1'b0;
            pixel_data     <= 24'h0;
            pixel_index    <= 8'd0;
            frame_done     <= 1'b0;
            frame_pixels   <= 8'd0;
            frame_partial  <= 1'b0;
            frame_overflow <= 1'b0;
            bit_error      <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= w_bit_err;

            // Low counter tracks consecutive s==0 cycles in every state and
            // holds once a full gap is reached.
            if (w_s || w_sync_exit || w_frame_end) r_low_cnt <= '0;
            else if (!w_low_full)                  r_low_cnt <= r_low_cnt + 1'b1;
            else                                   r_low_cnt <= r_low_cnt;

            if ((r_state == ST_IDLE || r_state == ST_LOW) && w_rise)
                r_high_cnt <= {{(L_HCNT_W-1){1'b0}}, 1'b1};
            else if (r_state == ST_HIGH && w_s && !w_high_over)
                r_high_cnt <= r_high_cnt + 1'b1;
            else if (r_state != ST_HIGH)
                r_high_cnt <= '0;
            else
                r_high_cnt <= r_high_cnt;

            if (r_state == ST_SYNC || r_state == ST_ERROR) begin
                // Anything received before a clean gap is discarded.
                r_bit_cnt    <= 5'd0;
                r_shift      <= 24'h0;
                r_next_index <= 8'd0;
                r_pix_cnt    <= 8'd0;
            end else if (w_bit_done) begin
                r_shift <= w_shift_next;
                if (r_bit_cnt == 5'd23) begin
                    r_bit_cnt    <= 5'd0;
                    pixel_valid  <= 1'b1;
                    // Wire order is G,R,B; output packing is {R,G,B}.
                    pixel_data   <= {w_shift_next[15:8], w_shift_next[23:16], w_shift_next[7:0]};
                    pixel_index  <= r_next_index;
                    r_next_index <= r_next_index + 8'd1;
                    if (r_pix_cnt != 8'd255) r_pix_cnt <= r_pix_cnt + 8'd1;
                    else                     r_pix_cnt <= r_pix_cnt;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end else if (w_frame_end) begin
                frame_done     <= 1'b1;
                frame_pixels   <= r_pix_cnt;
                frame_partial  <= (r_bit_cnt != 5'd0);
                frame_overflow <= (r_pix_cnt > L_MAX_PIX);
                r_bit_cnt      <= 5'd0;
                r_next_index   <= 8'd0;
                r_pix_cnt      <= 8'd0;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx
// Directed bench for neopixel_rx at 125 MHz with hand-computed expectations.
// A negedge monitor records every pixel_valid / frame_done / bit_error strobe;
// the stimulus sequence then compares the recorded events to expected values.
module tb_neopixel_rx;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        din   = 1'b0;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic [7:0]  frame_pixels;
    logic        frame_partial;
    logic        frame_overflow;
    logic        bit_error;

    neopixel_rx #(
        .C_FREQ_HZ    (125000000),
        .C_MAX_PIXELS (12)
    ) dut (
        .neopixel_clock   (clk),
        .neopixel_reset_n (rst_n),
        .neopixel_din     (din),
        .pixel_valid      (pixel_valid),
        .pixel_data       (pixel_data),
        .pixel_index      (pixel_index),
        .frame_done       (frame_done),
        .frame_pixels     (frame_pixels),
        .frame_partial    (frame_partial),
        .frame_overflow   (frame_overflow),
        .bit_error        (bit_error)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log filled by the monitor.
    logic [31:0] pix_q[$];
    logic [31:0] frm_q[$];
    int          err_cnt  = 0;
    int          both_cnt = 0;
    int          lat_last = -1;
    int          fall_cyc = 0;

    always @(negedge clk) begin
        if (pixel_valid) begin
            pix_q.push_back({pixel_index, pixel_data});
            lat_last = cyc - fall_cyc;
        end
        if (frame_done) frm_q.push_back({22'd0, frame_pixels, frame_partial, frame_overflow});
        if (bit_error) err_cnt++;
        if (pixel_valid && frame_done) both_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] frm(input logic [7:0] p, input logic part, input logic ovf);
        return {22'd0, p, part, ovf};
    endfunction

    // Hold din at v for n cycles; records the cycle of each falling edge.
    task automatic drive(input logic v, input int n);
        if (din && !v) fall_cyc = cyc;
        din = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input bit full_low);
        drive(1'b1, b ? 100 : 50);
        drive(1'b0, full_low ? (b ? 55 : 108) : 5);
    endtask

    task automatic send_pixel(input logic [23:0] grb, input bit full_low);
        for (int i = 23; i >= 0; i--) send_bit(grb[i], full_low);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(pixel_valid),    32'h0);
        check({tag, "_data"},    32'(pixel_data),     32'h0);
        check({tag, "_index"},   32'(pixel_index),    32'h0);
        check({tag, "_fdone"},   32'(frame_done),     32'h0);
        check({tag, "_fpix"},    32'(frame_pixels),   32'h0);
        check({tag, "_partial"}, 32'(frame_partial),  32'h0);
        check({tag, "_ovf"},     32'(frame_overflow), 32'h0);
        check({tag, "_berr"},    32'(bit_error),      32'h0);
    endtask

    initial begin
        int p0;
        int f0;
        int e0;
        logic [21:0] tail;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Startup gap: sync only, no frame_done.
        drive(1'b0, 6300);
        check("start_no_frame", 32'(frm_q.size()), 32'd0);

        // Glitch pulse of 18 cycles after three good bits.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        drive(1'b1, 18);
        drive(1'b0, 6300);
        check("glitch_err",      32'(err_cnt),      32'd1);
        check("glitch_no_pix",   32'(pix_q.size()), 32'd0);
        check("glitch_no_frame", 32'(frm_q.size()), 32'd0);

        // Over-long pulse of 189 cycles, then the 7000-cycle lead-in gap.
        drive(1'b1, 189);
        drive(1'b0, 7000);
        check("long_err",      32'(err_cnt),      32'd2);
        check("long_no_pix",   32'(pix_q.size()), 32'd0);
        check("long_no_frame", 32'(frm_q.size()), 32'd0);

        // G=FF R=80 B=00 with full transmitter timing.
        send_pixel({8'hFF, 8'h80, 8'h00}, 1'b1);
        drive(1'b0, 6300);
        check("px1_count",   32'(pix_q.size()), 32'd1);
        check("px1_entry",   pix_q[0],          {8'd0, 24'h80FF00});
        check("px1_latency", 32'(lat_last),     32'd3);
        check("px1_frames",  32'(frm_q.size()), 32'd1);
        check("px1_frame",   frm_q[0],          frm(8'd1, 1'b0, 1'b0));

        // 13 pixels; pixel 0 begins with 74- and 75-cycle pulses, and a
        // 6000-cycle gap separates pixels 0 and 1.
        p0 = pix_q.size();
        f0 = frm_q.size();
        drive(1'b1, 74);
        drive(1'b0, 5);
        drive(1'b1, 75);
        drive(1'b0, 5);
        tail = {6'b111111, 8'h00, 8'hAA};
        for (int i = 21; i >= 0; i--) send_bit(tail[i], 1'b0);
        drive(1'b0, 6000);
        check("gap6000_no_frame", 32'(frm_q.size()), 32'(f0));
        for (int k = 1; k < 13; k++) send_pixel({8'(k), 8'h00, 8'h00}, 1'b0);
        drive(1'b0, 6300);
        check("ovf_count", 32'(pix_q.size()), 32'(p0 + 13));
        check("ovf_px0",   pix_q[p0],         {8'd0, 24'h007FAA});
        for (int k = 1; k < 13; k++)
            check($sformatf("ovf_px%0d", k), pix_q[p0 + k], {8'(k), 8'h00, 8'(k), 8'h00});
        check("ovf_frames", 32'(frm_q.size()), 32'(f0 + 1));
        check("ovf_frame",  frm_q[f0],         frm(8'd13, 1'b0, 1'b1));

        // 10 stray bits then a gap.
        p0 = pix_q.size();
        f0 = frm_q.size();
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        drive(1'b0, 6300);
        check("part_no_pix", 32'(pix_q.size()), 32'(p0));
        check("part_frames", 32'(frm_q.size()), 32'(f0 + 1));
        check("part_frame",  frm_q[f0],         frm(8'd0, 1'b1, 1'b0));

        // Reset during pixel 2, released with din high.
        send_pixel({8'h11, 8'h22, 8'h33}, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        drive(1'b1, 20);
        rst_n = 1'b0;
        drive(1'b1, 3);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        p0 = pix_q.size();
        f0 = frm_q.size();
        e0 = err_cnt;
        drive(1'b1, 30);
        drive(1'b0, 6249);
        send_pixel({8'hAA, 8'hBB, 8'hCC}, 1'b0);
        check("short_gap_no_pix", 32'(pix_q.size()), 32'(p0));
        drive(1'b0, 6300);
        send_pixel({8'hAB, 8'hCD, 8'hEF}, 1'b0);
        drive(1'b0, 20);
        check("post_rst_count",    32'(pix_q.size()), 32'(p0 + 1));
        check("post_rst_entry",    pix_q[p0],         {8'd0, 24'hCDABEF});
        check("post_rst_no_frame", 32'(frm_q.size()), 32'(f0));
        check("post_rst_no_err",   32'(err_cnt),      32'(e0));

        check("no_valid_with_done", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neopixel_rx.md
NEOPIXEL_RX -- requirements
Module: neopixel_rx

Interface
REQ-001 SHALL have parameter C_FREQ_HZ, default 125000000, neopixel_clock frequency in Hz; all cycle constants scale by C_FREQ_HZ/125000000.
REQ-002 SHALL have parameter C_MAX_PIXELS, default 12, pixels counted per frame before frame_overflow sets.
REQ-003 SHALL have port neopixel_clock, input, 1, the single clock.
REQ-004 SHALL have port neopixel_reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port neopixel_din, input, 1, asynchronous WS2812 serial line, GRB order, MSB first.
REQ-006 SHALL have port pixel_valid, output, 1, one-cycle strobe marking a complete 24-bit pixel.
REQ-007 SHALL have port pixel_data, output, 24, {red,green,blue}, the same packing as the control-interface word bits [23:0].
REQ-008 SHALL have port pixel_index, output, 8, position of the pixel in the frame, 0-based.
REQ-009 SHALL have port frame_done, output, 1, one-cycle strobe on a detected latch (reset) gap.
REQ-010 SHALL have port frame_pixels, output, 8, count of complete pixels, valid with frame_done.
REQ-011 SHALL have port frame_partial, output, 1, high with frame_done when 1..23 stray bits were discarded.
REQ-012 SHALL have port frame_overflow, output, 1, high with frame_done when pixels exceeded C_MAX_PIXELS.
REQ-013 SHALL have port bit_error, output, 1, one-cycle strobe on a high-pulse timing violation.

Function
REQ-014 SHALL synchronize neopixel_din through two flops; all timing uses the synchronized sample s.
REQ-015 SHALL use cycle constants at 125 MHz: C_GLITCH_CYCLES=19, C_T1_MIN_CYCLES=75, C_MAX_HIGH_CYCLES=188, C_RESET_CYCLES=6250.
REQ-016 SHALL use states ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW, ST_ERROR.
REQ-017 ST_SYNC: count consecutive s==0 cycles; s==1 clears the count; at C_RESET_CYCLES go ST_IDLE with no frame_done.
REQ-018 ST_IDLE/ST_LOW: a rising edge of s SHALL go ST_HIGH with the high counter set to 1.
REQ-019 ST_HIGH SHALL increment the high counter each cycle s==1, saturating at C_MAX_HIGH_CYCLES+1.
REQ-020 On a falling edge with high count < C_GLITCH_CYCLES or > C_MAX_HIGH_CYCLES, the block SHALL pulse bit_error and go ST_ERROR.
REQ-021 A high count of C_MAX_HIGH_CYCLES+1 SHALL trigger the same error immediately, without waiting for the falling edge.
REQ-022 Otherwise the bit SHALL be 1 if high count >= C_T1_MIN_CYCLES, else 0; it SHALL shift into a 24-bit register and go ST_LOW.
REQ-023 On the 24th bit, pixel_valid SHALL assert the cycle after the falling edge is seen on s.
REQ-024 pixel_data SHALL be reordered from the GRB wire order to the {R,G,B} output packing.
REQ-025 pixel_index SHALL increment after each pixel and wrap 255->0; the bit count SHALL clear.
REQ-026 ST_LOW SHALL count s==0 cycles; a low gap shorter than C_RESET_CYCLES is legal and is not an error.
REQ-027 When the low count reaches C_RESET_CYCLES (also from ST_IDLE after any pixel), the block SHALL pulse frame_done.
REQ-028 On frame_done, frame_pixels, frame_partial and frame_overflow SHALL be valid; pixel_index, pixel count and bit count SHALL then clear; next state ST_IDLE.
REQ-029 ST_IDLE with no pixel received SHALL NOT repeat frame_done.
REQ-030 ST_ERROR SHALL discard any partial pixel and act as ST_SYNC (no frame_done, counters cleared on exit).
REQ-031 The pixel counter SHALL saturate at 255; frame_overflow = count > C_MAX_PIXELS.
REQ-032 pixel_valid and frame_done SHALL never assert in the same cycle.
REQ-033 Latency from the din falling edge to pixel_valid SHALL be 3 cycles (2 synchronizer + 1).

Reset
REQ-034 Reset SHALL force immediately: state ST_SYNC, all counters 0, all outputs 0 (pixel_data 24'h0, frame_pixels 8'd0).
REQ-035 Reset asserted mid-bit or mid-frame SHALL discard all partial data; no strobe SHALL be emitted until a full C_RESET_CYCLES low gap follows release.

Structure
REQ-036 The timing constants (C_GLITCH/T1_MIN/MAX_HIGH/RESET_CYCLES plus the transmitter T0H/T0L/T1H/T1L/START) SHALL live in package neopixel_pkg, shared with the transmitter.
REQ-037 The state encoding SHALL live in neopixel_pkg.
REQ-038 The synchronizer plus rise/fall edge detect SHALL be sub-module neopixel_sync.

Verification (125 MHz; TX timing T0H=50, T0L=108, T1H=100, T1L=55 cycles)
REQ-039 7000 low, then G=FF R=80 B=00, then 6250 low -> one pixel_valid with pixel_data=24'h80FF00, index 0; then frame_done with frame_pixels=1, partial=0, overflow=0.
REQ-040 13 pixels (C_MAX_PIXELS=12) -> valid strobes with index 0..12; frame_pixels=13, frame_overflow=1.
REQ-041 High pulses of 74 and 75 cycles -> bits 0 and 1; pulses of 18 and 189 cycles -> bit_error, no pixel_valid, no frame_done until the next gap; the following frame decodes correctly.
REQ-042 10 bits, then 6250 low -> frame_done, frame_pixels=0, frame_partial=1.
REQ-043 Reset during pixel 2, released while din is high -> all outputs 0; 6249-cycle low gap yields no decode; after 6250 low, the next frame decodes from index 0.
REQ-044 A 6000-cycle low gap between pixels -> no frame_done; indices continue 0, 1.
